// File: rtl/genius_controller_if.sv
// Signal bundle between the Genius control FSM and its datapath.
// Inputs are levels sampled on every rising clock edge; there is no valid/ready handshake, and outputs are Moore decodes valid for the whole cycle.
interface genius_controller_if;
    logic       enter;
    logic       end_FPGA;
    logic       end_User;
    logic       end_time;
    logic       win;
    logic       match;
    logic       R1;
    logic       R2;
    logic       E1;
    logic       E2;
    logic       E3;
    logic       E4;
    logic       SEL;
    logic       fault;
    logic [2:0] state_o;

    // master: the controller; slave: the datapath / stimulus side
    modport master (
        input  enter, end_FPGA, end_User, end_time, win, match,
        output R1, R2, E1, E2, E3, E4, SEL, fault, state_o
    );
    modport slave (
        output enter, end_FPGA, end_User, end_time, win, match,
        input  R1, R2, E1, E2, E3, E4, SEL, fault, state_o
    );
endinterface

// File: rtl/genius_controller.sv
// Control FSM for the Genius game: sequences setup, FPGA display, user entry,
// comparison and round advance, with a watchdog on the display phase.
module genius_controller #(
    parameter longint unsigned SEQ_TIMEOUT = 64'd3_200_000_000,
    parameter int              TO_W        = 32
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    genius_controller_if.master bus
);
    typedef enum logic [2:0] {
        INIT     = 3'd0,
        SETUP    = 3'd1,
        SEQUENCE = 3'd2,
        PLAY     = 3'd3,
        CHECK    = 3'd4,
        NEXT     = 3'd5,
        RESULT   = 3'd6,
        ILLEGAL  = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SEQ_TIMEOUT - 64'd1);
    localparam logic [TO_W-1:0] CNT_MAX = '1;
    localparam logic            WD_EN   = (SEQ_TIMEOUT != 64'd0);

    state_t          state;
    state_t          next_state;
    logic            enter_q;
    logic            enter_rise;
    logic [TO_W-1:0] count;
    logic            expired;
    logic            set_fault;
    logic            fault_r;
    logic            r1, r2, e1, e2, e3, e4, sel;

    assign enter_rise = bus.enter & ~enter_q;
    assign expired    = WD_EN && (count == TO_LAST);

    // enter_q resets high so an enter held through reset never looks like an edge
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state   <= INIT;
            enter_q <= 1'b1;
            count   <= '0;
            fault_r <= 1'b0;
        end else begin
            state   <= next_state;
            enter_q <= bus.enter;
            if (next_state == SEQUENCE && state != SEQUENCE)
                count <= '0;
            else if (state == SEQUENCE && count != CNT_MAX)
                count <= count + 1'b1;
            if (state == INIT)
                fault_r <= 1'b0;
            else if (set_fault)
                fault_r <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        set_fault  = 1'b0;
        r1  = 1'b0;
        r2  = 1'b0;
        e1  = 1'b0;
        e2  = 1'b0;
        e3  = 1'b0;
        e4  = 1'b0;
        sel = 1'b0;
        case (state)
            INIT: begin
                r1 = 1'b1;
                r2 = 1'b1;
                sel = 1'b1;
                next_state = SETUP;
            end
            SETUP: begin
                e1 = 1'b1;
                sel = 1'b1;
                if (enter_rise) next_state = SEQUENCE;
            end
            SEQUENCE: begin
                e3 = 1'b1;
                sel = 1'b1;
                // a display finishing on the expiry cycle is a success, not a fault
                if (bus.end_FPGA) begin
                    next_state = PLAY;
                end else if (expired) begin
                    next_state = RESULT;
                    set_fault  = 1'b1;
                end
            end
            PLAY: begin
                e2 = 1'b1;
                sel = 1'b1;
                if (bus.end_User)      next_state = CHECK;
                else if (bus.end_time) next_state = RESULT;
            end
            CHECK: begin
                sel = 1'b1;
                if (!bus.match || bus.win) next_state = RESULT;
                else                       next_state = NEXT;
            end
            NEXT: begin
                e4 = 1'b1;
                r2 = 1'b1;
                sel = 1'b1;
                next_state = SEQUENCE;
            end
            RESULT: begin
                if (enter_rise) next_state = INIT;
            end
            default: next_state = INIT;
        endcase
    end

    assign bus.R1      = r1;
    assign bus.R2      = r2;
    assign bus.E1      = e1;
    assign bus.E2      = e2;
    assign bus.E3      = e3;
    assign bus.E4      = e4;
    assign bus.SEL     = sel;
    assign bus.fault   = fault_r;
    assign bus.state_o = state;
endmodule

// File: tb/tb_genius_controller.sv
// Bench for genius_controller: directed game scenarios plus random play,
// checked cycle by cycle against a phase-level model of the game rules.
module tb_genius_controller;
    localparam longint unsigned TIMEOUT = 64'd8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #10 clk = ~clk;

    genius_controller_if bus ();

    genius_controller #(
        .SEQ_TIMEOUT (TIMEOUT),
        .TO_W        (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // model: game phase number (0..6), sticky fault, last enter level, cycles spent in display
    int m_phase      = 0;
    bit m_fault      = 1'b0;
    bit m_prev_en    = 1'b1;
    int m_seq_cycles = 0;

    // {state, fault, R1, R2, E1, E2, E3, E4, SEL}
    function automatic logic [10:0] expect_out(int ph, bit f);
        logic [6:0] ctl;
        logic [2:0] enc;
        case (ph)
            0:       ctl = 7'b1100001;
            1:       ctl = 7'b0010001;
            2:       ctl = 7'b0000101;
            3:       ctl = 7'b0001001;
            4:       ctl = 7'b0000001;
            5:       ctl = 7'b0100011;
            default: ctl = 7'b0000000;
        endcase
        enc = ph[2:0];
        return {enc, f, ctl};
    endfunction

    function automatic logic [10:0] observe();
        return {bus.state_o, bus.fault, bus.R1, bus.R2, bus.E1, bus.E2,
                bus.E3, bus.E4, bus.SEL};
    endfunction

    task automatic check(string name, logic [10:0] got, logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // monitor: one expected response per clock while the game runs
    always @(posedge clk) begin
        logic [10:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle_outputs", observe(), e);
        end
    end

    task automatic model_step(bit en, bit fpga, bit usr, bit tim, bit mat, bit wn);
        bit rise;
        int nxt;
        rise = en && !m_prev_en;
        m_prev_en = en;
        nxt = m_phase;
        case (m_phase)
            0: begin nxt = 1; m_fault = 1'b0; end
            1: if (rise) nxt = 2;
            2: begin
                if (fpga) nxt = 3;
                else if (TIMEOUT != 0 && m_seq_cycles == int'(TIMEOUT)) begin
                    nxt = 6;
                    m_fault = 1'b1;
                end
            end
            3: if (usr) nxt = 4; else if (tim) nxt = 6;
            4: nxt = (mat && !wn) ? 5 : 6;
            5: nxt = 2;
            6: if (rise) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 2 && m_phase != 2) m_seq_cycles = 1;
        else if (m_phase == 2)        m_seq_cycles++;
        m_phase = nxt;
        exp_q.push_back(expect_out(m_phase, m_fault));
    endtask

    task automatic drive(bit en, bit fpga, bit usr, bit tim, bit mat, bit wn);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.enter    = en;
        bus.end_FPGA = fpga;
        bus.end_User = usr;
        bus.end_time = tim;
        bus.match    = mat;
        bus.win      = wn;
        model_step(en, fpga, usr, tim, mat, wn);
    endtask

    task automatic rand_drive();
        drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
    endtask

    task automatic assert_reset(bit en);
        #3;
        rst_n     = 1'b0;
        bus.enter = en;
        #1;
        check("async_reset", observe(), expect_out(0, 1'b0));
        m_phase      = 0;
        m_fault      = 1'b0;
        m_prev_en    = 1'b1;
        m_seq_cycles = 0;
        repeat (2) @(negedge clk);
        check("reset_hold", observe(), expect_out(0, 1'b0));
    endtask

    initial begin
        bus.enter    = 1'b1;
        bus.end_FPGA = 1'b0;
        bus.end_User = 1'b0;
        bus.end_time = 1'b0;
        bus.match    = 1'b0;
        bus.win      = 1'b0;
        assert_reset(1'b1);

        // enter held across release: SETUP waits for a fresh edge
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // good round, then simultaneous end_User/end_time
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        // watchdog expiry from the NEXT-entered display
        repeat (10) drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        // end_FPGA on the expiry cycle wins
        repeat (7) drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        // enter pulses ignored in PLAY, then timeout loss
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        // mismatch loss
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        // win
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 1);
        // reset mid-PLAY
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        @(posedge clk);
        assert_reset(1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk);
                assert_reset(1'($urandom_range(0, 1)));
            end
            rand_drive();
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/genius_controller.md
# genius_controller

Control FSM for the Genius game datapath. It sequences the datapath through setup, FPGA sequence display, user entry, comparison and round advance by driving the datapath's reset, enable and display-select lines (R1, R2, E1–E4, SEL). It consumes the datapath status flags (end_FPGA, end_User, end_time, win, match). It sits beside the datapath in the top level, and the two share the same 50 MHz clock.

## Interface

- SEQ_TIMEOUT, default 50_000_000*64: max cycles allowed in SEQUENCE before watchdog fault; 0 disables watchdog.
- TO_W, default 32: width of watchdog counter; must satisfy 2^TO_W > SEQ_TIMEOUT.

- CLOCK_50  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- enter  in  1  start/confirm request, already synchronized, active-high level.
- end_FPGA  in  1  FPGA sequence display finished.
- end_User  in  1  user has entered ROUND+1 keys.
- end_time  in  1  user time limit expired.
- win  in  1  current round is the final round.
- match  in  1  user sequence equals FPGA sequence (valid with end_User).
- R1  out  1  datapath global reset (setup, round, clock divider).
- R2  out  1  datapath per-round reset (time, FPGA/user counters and registers).
- E1  out  1  setup register enable.
- E2  out  1  user phase enable (time counter, user counter/register).
- E3  out  1  FPGA sequence counter/register enable.
- E4  out  1  round counter increment.
- SEL  out  1  display select: 1 = game status, 0 = result text.
- fault  out  1  sticky watchdog fault, cleared in INIT.
- state_o  out  3  current state encoding, debug.

## Operation

- States and encodings: INIT=0, SETUP=1, SEQUENCE=2, PLAY=3, CHECK=4, NEXT=5, RESULT=6. Encoding 7 is illegal and goes to INIT next cycle.
- Moore outputs, decoded from the state register only:
  - INIT: R1=1, R2=1, SEL=1.
  - SETUP: E1=1, SEL=1.
  - SEQUENCE: E3=1, SEL=1.
  - PLAY: E2=1, SEL=1.
  - CHECK: SEL=1.
  - NEXT: E4=1, R2=1, SEL=1.
  - RESULT: SEL=0.
  - All outputs not listed for a state are 0.
- Enter edge: enter_rise = enter & ~enter_q; enter_q is registered every cycle.
- Transitions:
  - INIT → SETUP, unconditionally; also clears fault.
  - SETUP → SEQUENCE on enter_rise.
  - SEQUENCE → PLAY on end_FPGA.
  - SEQUENCE → RESULT with fault set on watchdog expiry.
  - PLAY → CHECK on end_User.
  - PLAY → RESULT on end_time with end_User=0.
  - CHECK → RESULT if !match.
  - CHECK → RESULT if match & win.
  - CHECK → NEXT if match & !win.
  - NEXT → SEQUENCE, unconditionally (one cycle).
  - RESULT → INIT on enter_rise.
- Watchdog: counter clears on every entry to SEQUENCE and increments each cycle in SEQUENCE. Expiry is the cycle the count equals SEQ_TIMEOUT-1. Counter saturates and never wraps.
- enter_rise is ignored in SEQUENCE, PLAY, CHECK and NEXT.
- Simultaneous events:
  - end_User and end_time in the same PLAY cycle: end_User wins, go to CHECK.
  - end_FPGA and watchdog expiry in the same cycle: end_FPGA wins, no fault.

## Timing

- Reset asserted: state=INIT, enter_q=1, fault=0, counter=0. Outputs take INIT values: R1=1, R2=1, SEL=1, all others 0, state_o=0.
- enter_q resets to 1 so that enter held through reset does not produce an edge.
- Reset mid-game: immediate return to INIT values, independent of clock.
- First rising edge after reset release: INIT → SETUP. R1 and R2 therefore pulse for at least one full cycle.
- Latency is one cycle from a sampled input condition to the new state and its outputs.
- E4 is exactly one cycle per round. R2 is high in the same cycle, so per-round counters restart before SEQUENCE.
- CHECK lasts exactly one cycle. match and win must be stable in the cycle after end_User is sampled; the datapath guarantees this.
- Holding enter high produces exactly one enter_rise.

## Test plan

- Reset/start: hold reset=0, then release → R1=R2=1 and SEL=1 for one cycle, then state_o=1 with E1=1. Pulse enter → next cycle state_o=2, E3=1.
- Good round: in SEQUENCE assert end_FPGA → PLAY (E2=1). Assert end_User=1, match=1, win=0 → CHECK one cycle, NEXT one cycle (E4=1, R2=1), then SEQUENCE.
- Win: in PLAY assert end_User=1, match=1, win=1 → CHECK then RESULT with SEL=0 and all enables 0. Pulse enter → INIT → SETUP.
- Loss paths: end_User=1 with match=0 → RESULT via CHECK. Separately, end_time=1 alone in PLAY → RESULT next cycle. Both end_User=1 and end_time=1 with match=1, win=0 → CHECK then NEXT.
- Watchdog: SEQ_TIMEOUT=8, end_FPGA held 0 → RESULT on the 9th cycle after entry with fault=1. Enter → INIT clears fault. Same run with end_FPGA asserted on cycle 8 → PLAY, fault=0.
- Robustness: enter held high across reset release → no SETUP exit until enter falls and rises again. Reset pulsed mid-PLAY → immediate INIT outputs. Enter pulses in PLAY → ignored.
